// File: rtl/pipe_pkg.sv
// Shared decode definitions: instruction field positions, opcode constants,
// instruction classes and the ID/EX register layout.
package pipe_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RS1_HI = 20;
  localparam int RS1_LO = 16;
  localparam int RS2_HI = 15;
  localparam int RS2_LO = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam logic [5:0]      OP_LOAD      = 6'b001001;
  localparam logic [5:0]      OP_STORE     = 6'b001000;
  localparam logic [2:0]      OP_RR_PREFIX = 3'b000;
  localparam logic [XLEN-1:0] NOP          = 32'h0;

  typedef enum logic [1:0] {
    CLS_RR,
    CLS_LOAD,
    CLS_STORE,
    CLS_IMM
  } instr_class_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
  } idex_t;

  function automatic instr_class_e classify(input logic [5:0] op);
    if (op[5:3] == OP_RR_PREFIX) return CLS_RR;
    if (op == OP_LOAD)           return CLS_LOAD;
    if (op == OP_STORE)          return CLS_STORE;
    return CLS_IMM;
  endfunction

  function automatic logic [XLEN-1:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file, two combinational read ports, one write port; R0 is hardwired 0.
// Define DECODE_WB_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n_i,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i
);

  logic [XLEN-1:0] mem_q [NREGS];

  // NOTE: every entry is cleared on reset because software relies on a zeroed
  // register file; this blocks RAM-macro inference, which is acceptable at 32x32.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (wb_en_i && (wb_addr_i != 5'd0)) begin
      // NOTE: state updates use <= so every read in this edge sees pre-edge values.
      mem_q[wb_addr_i] <= wb_data_i;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
    if (addr == 5'd0) return '0;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en_i && (addr == wb_addr_i)) return wb_data_i;
`endif
    return mem_q[addr];
  endfunction

  assign rdata1_o = read_port(raddr1_i);
  assign rdata2_o = read_port(raddr2_i);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: register read, immediate sign extension, load-use hazard
// detection and the ID/EX pipeline register. Bypass build: DECODE_WB_BYPASS_EN.
module decode_stage
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] IR_F,
  input  logic [XLEN-1:0] NPC_F,
  input  logic            valid_F,
  input  logic            flush_D,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall_F,
  output logic [XLEN-1:0] IR_D,
  output logic [XLEN-1:0] NPC_D,
  output logic [XLEN-1:0] A_D,
  output logic [XLEN-1:0] B_D,
  output logic [XLEN-1:0] Imm_D,
  output logic            valid_D
);

  idex_t idex_q, idex_d;

  logic [4:0]      rd_f, rs1_f, rs2_f, raddr2;
  logic [15:0]     imm_f;
  instr_class_e    cls_f;
  logic [XLEN-1:0] rdata1, rdata2;
  logic [4:0]      ld_rd;
  logic            ld_in_ex, src_match;

  assign rd_f  = IR_F[RD_HI:RD_LO];
  assign rs1_f = IR_F[RS1_HI:RS1_LO];
  assign rs2_f = IR_F[RS2_HI:RS2_LO];
  assign imm_f = IR_F[IMM_HI:IMM_LO];
  assign cls_f = classify(IR_F[OP_HI:OP_LO]);

  // Port 2 reads R0 (always 0) for classes that have no second source.
  assign raddr2 = (cls_f == CLS_RR)    ? rs2_f :
                  (cls_f == CLS_STORE) ? rd_f  : 5'd0;

  regfile u_regfile (
    .clk       (clk),
    .rst_n_i   (reset),
    .raddr1_i  (rs1_f),
    .raddr2_i  (raddr2),
    .rdata1_o  (rdata1),
    .rdata2_o  (rdata2),
    .wb_en_i   (wb_en),
    .wb_addr_i (wb_addr),
    .wb_data_i (wb_data)
  );

  assign ld_rd     = idex_q.ir[RD_HI:RD_LO];
  assign ld_in_ex  = idex_q.valid && (classify(idex_q.ir[OP_HI:OP_LO]) == CLS_LOAD) &&
                     (ld_rd != 5'd0);
  assign src_match = (rs1_f == ld_rd) ||
                     ((cls_f == CLS_RR)    && (rs2_f == ld_rd)) ||
                     ((cls_f == CLS_STORE) && (rd_f  == ld_rd));

  // Flush and reset both override the hazard; the bubble clears the LOAD next cycle.
  assign stall_F = reset && !flush_D && valid_F && ld_in_ex && src_match;

  always_comb begin
    // NOTE: defaulting idex_d to the bubble first keeps this block latch-free.
    idex_d       = '0;
    idex_d.ir    = NOP;
    idex_d.npc   = idex_q.npc;
    if (valid_F && !flush_D && !stall_F) begin
      idex_d.valid = 1'b1;
      idex_d.ir    = IR_F;
      idex_d.npc   = NPC_F;
      idex_d.a     = rdata1;
      idex_d.b     = rdata2;
      idex_d.imm   = sign_ext16(imm_f);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign valid_D = idex_q.valid;
  assign IR_D    = idex_q.ir;
  assign NPC_D   = idex_q.npc;
  assign A_D     = idex_q.a;
  assign B_D     = idex_q.b;
  assign Imm_D   = idex_q.imm;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, register read, load-use stall, flush,
// sign extension, R0 and same-cycle writeback (expectation follows DECODE_WB_BYPASS_EN).
module tb_decode_stage;

  localparam logic [5:0] OP_ADD   = 6'b000001;
  localparam logic [5:0] OP_ADDI  = 6'b010000;
  localparam logic [5:0] OP_LD    = 6'b001001;
  localparam logic [5:0] OP_ST    = 6'b001000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR_F, NPC_F;
  logic        valid_F, flush_D, wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall_F, valid_D;
  logic [31:0] IR_D, NPC_D, A_D, B_D, Imm_D;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk     (clk),
    .reset   (reset),
    .IR_F    (IR_F),
    .NPC_F   (NPC_F),
    .valid_F (valid_F),
    .flush_D (flush_D),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .stall_F (stall_F),
    .IR_D    (IR_D),
    .NPC_D   (NPC_D),
    .A_D     (A_D),
    .B_D     (B_D),
    .Imm_D   (Imm_D),
    .valid_D (valid_D)
  );

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [15:0] lo);
    return {op, rd, rs1, lo};
  endfunction

  function automatic logic [31:0] enc_rr(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    return {OP_ADD, rd, rs1, rs2, 11'h0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] npc, input logic v);
    IR_F = ir; NPC_F = npc; valid_F = v;
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wb_en = en; wb_addr = addr; wb_data = data;
  endtask

  logic [31:0] add_a, st_i, exp_r7;

  initial begin
    reset = 1'b0; flush_D = 1'b0;
    wb(1'b1, 5'd5, 32'hFFFF_FFFF);
    drive(enc_rr(5'd1, 5'd5, 5'd0), 32'h0000_0050, 1'b1);
    tick(); tick();
    check("rst_ir",    IR_D,    32'h0);
    check("rst_npc",   NPC_D,   32'h0);
    check("rst_a",     A_D,     32'h0);
    check("rst_b",     B_D,     32'h0);
    check("rst_imm",   Imm_D,   32'h0);
    check("rst_valid", {31'h0, valid_D}, 32'h0);
    check("rst_stall", {31'h0, stall_F}, 32'h0);

    // First post-reset cycle decodes normally; R5 write during reset was dropped
    reset = 1'b1; wb(1'b0, 5'd0, 32'h0);
    drive(enc_rr(5'd1, 5'd5, 5'd0), 32'h0000_0100, 1'b1);
    tick();
    check("r5_zero",    A_D,     32'h0);
    check("first_valid", {31'h0, valid_D}, 32'h1);
    check("first_npc",  NPC_D,   32'h0000_0100);

    wb(1'b1, 5'd3, 32'h0000_1234);
    drive(32'h0, 32'h0, 1'b0);
    tick();
    check("inv_valid", {31'h0, valid_D}, 32'h0);
    check("inv_ir",    IR_D,  32'h0);
    check("inv_npc",   NPC_D, 32'h0000_0100);
    wb(1'b1, 5'd4, 32'h0000_4444);
    tick();

    wb(1'b0, 5'd0, 32'h0);
    drive(enc_rr(5'd1, 5'd3, 5'd0), 32'h0000_0104, 1'b1);
    tick();
    check("rr_a",     A_D, 32'h0000_1234);
    check("rr_b",     B_D, 32'h0);
    check("rr_valid", {31'h0, valid_D}, 32'h1);

    // Load-use: LOAD r4, then RR reading r4
    drive(enc(OP_LD, 5'd4, 5'd3, 16'h0008), 32'h0000_0108, 1'b1);
    check("ld_nostall", {31'h0, stall_F}, 32'h0);
    tick();
    check("ld_ir",  IR_D,  enc(OP_LD, 5'd4, 5'd3, 16'h0008));
    check("ld_imm", Imm_D, 32'h0000_0008);
    check("ld_a",   A_D,   32'h0000_1234);
    check("ld_b",   B_D,   32'h0);
    add_a = enc_rr(5'd2, 5'd4, 5'd3);
    drive(add_a, 32'h0000_010C, 1'b1);
    check("lu_stall", {31'h0, stall_F}, 32'h1);
    tick();
    check("lu_bub_valid", {31'h0, valid_D}, 32'h0);
    check("lu_bub_ir",    IR_D,  32'h0);
    check("lu_bub_a",     A_D,   32'h0);
    check("lu_bub_npc",   NPC_D, 32'h0000_0108);
    check("lu_stall_end", {31'h0, stall_F}, 32'h0);
    tick();
    check("lu_valid", {31'h0, valid_D}, 32'h1);
    check("lu_ir",    IR_D,  add_a);
    check("lu_a",     A_D,   32'h0000_4444);
    check("lu_b",     B_D,   32'h0000_1234);
    check("lu_npc",   NPC_D, 32'h0000_010C);

    // LOAD r4 then STORE with data register r4
    drive(enc(OP_LD, 5'd4, 5'd3, 16'h0000), 32'h0000_0110, 1'b1);
    tick();
    st_i = enc(OP_ST, 5'd4, 5'd3, 16'hFFF0);
    drive(st_i, 32'h0000_0114, 1'b1);
    check("st_stall", {31'h0, stall_F}, 32'h1);
    tick();
    check("st_bub", {31'h0, valid_D}, 32'h0);
    tick();
    check("st_ir",  IR_D,  st_i);
    check("st_a",   A_D,   32'h0000_1234);
    check("st_b",   B_D,   32'h0000_4444);
    check("st_imm", Imm_D, 32'hFFFF_FFF0);

    // LOAD r0 never stalls; write to R0 ignored
    wb(1'b1, 5'd0, 32'hDEAD_BEEF);
    drive(enc(OP_LD, 5'd0, 5'd3, 16'h0000), 32'h0000_0118, 1'b1);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    drive(enc_rr(5'd5, 5'd0, 5'd0), 32'h0000_011C, 1'b1);
    check("r0_nostall", {31'h0, stall_F}, 32'h0);
    tick();
    check("r0_valid", {31'h0, valid_D}, 32'h1);
    check("r0_a",     A_D, 32'h0);

    // Flush beats a hazard
    drive(enc(OP_LD, 5'd4, 5'd3, 16'h0000), 32'h0000_0120, 1'b1);
    tick();
    flush_D = 1'b1;
    drive(enc_rr(5'd2, 5'd4, 5'd0), 32'h0000_0124, 1'b1);
    check("fl_stall", {31'h0, stall_F}, 32'h0);
    tick();
    flush_D = 1'b0;
    check("fl_valid", {31'h0, valid_D}, 32'h0);
    check("fl_ir",    IR_D, 32'h0);

    drive(enc(OP_ADDI, 5'd6, 5'd3, 16'hFFFE), 32'h0000_0128, 1'b1);
    tick();
    check("imm_sext", Imm_D, 32'hFFFF_FFFE);
    check("imm_a",    A_D,   32'h0000_1234);
    check("imm_b",    B_D,   32'h0);

    // Same-cycle writeback and read of R7
    wb(1'b1, 5'd7, 32'h0000_0077);
    drive(32'h0, 32'h0, 1'b0);
    tick();
    wb(1'b1, 5'd7, 32'hA5A5_A5A5);
    drive(enc_rr(5'd1, 5'd7, 5'd0), 32'h0000_012C, 1'b1);
    tick();
`ifdef DECODE_WB_BYPASS_EN
    exp_r7 = 32'hA5A5_A5A5;
`else
    exp_r7 = 32'h0000_0077;
`endif
    check("r7_collide", A_D, exp_r7);
    wb(1'b0, 5'd0, 32'h0);
    tick();
    check("r7_after", A_D, 32'hA5A5_A5A5);

    // Reset mid-stall wins; first post-reset decode is normal with cleared registers
    drive(enc(OP_LD, 5'd4, 5'd3, 16'h0000), 32'h0000_0130, 1'b1);
    tick();
    drive(enc_rr(5'd2, 5'd4, 5'd0), 32'h0000_0134, 1'b1);
    check("rs_stall_pre", {31'h0, stall_F}, 32'h1);
    reset = 1'b0;
    #1;
    check("rs_stall_rst", {31'h0, stall_F}, 32'h0);
    tick();
    check("rs_valid", {31'h0, valid_D}, 32'h0);
    check("rs_ir",    IR_D,  32'h0);
    check("rs_npc",   NPC_D, 32'h0);
    reset = 1'b1;
    #1;
    check("rs_nostall", {31'h0, stall_F}, 32'h0);
    tick();
    check("rs_dec_valid", {31'h0, valid_D}, 32'h1);
    check("rs_dec_a",     A_D,   32'h0);
    check("rs_dec_npc",   NPC_D, 32'h0000_0134);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
